mem_access_unit: RTL and testbench

- Initiator side of the data-memory interface: turns LDR/STR/LDRB/STRB requests from the ARM datapath into data-memory cycles (addr, dataIn, memoryEnable, readNotWrite) and returns load data.
- Data memory is word-addressed, has 1-cycle registered read data, and writes whole words only, so byte stores are done as read-modify-write.
- Sits between the execute stage and dataMemory; one request in flight at a time.

---
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the word-addressed data memory for LDR/STR/LDRB/STRB.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_store, req_byte        access kind: store/load, byte/word
//   req_addr, req_wdata        byte address and store data (byte store uses [7:0])
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_fault     load result (0 for stores) and misalignment fault
//   mem_addr, mem_wdata        word index and write data to memory
//   mem_en, mem_rnw            memory enable and read(1)/write(0)
//   mem_rdata                  registered memory read data (valid the cycle after a read)
// Optional: define MEM_ACCESS_ALIGN_CHECK_EN to fault misaligned word accesses
// without touching memory; otherwise resp_fault is tied 0 and addr[1:0] is ignored.
module mem_access_unit #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_rnw,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              store_q, byte_q;
    logic              accept, misalign;
    logic [4:0]        lane_lsb;
    logic [31:0]       load_data, merged;
    logic              unused;

    assign accept   = req_valid & req_ready;
    assign lane_lsb = {addr_q[1:0], 3'b000};
    assign unused   = ^req_addr[31:ADDR_W+2];

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misalign = accept & ~req_byte & (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = misalign ? RESP : (req_store & ~req_byte) ? WR : RD_ISSUE;
            RD_ISSUE: state_nxt = RD_CAPT;
            RD_CAPT:  state_nxt = store_q ? WR : RESP;
            WR:       state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Load extraction and byte-store merge work on the word that arrives in RD_CAPT
    always_comb begin
        merged = mem_rdata;
        merged[lane_lsb +: 8] = wdata_q[7:0];
        load_data = byte_q ? {24'd0, mem_rdata[lane_lsb +: 8]} : mem_rdata;
    end

    // Request latch, merged-word register and response data
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            byte_q     <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata;
                store_q <= req_store;
                byte_q  <= req_byte;
            end
            if (state == RD_CAPT && store_q) wdata_q <= merged;
            // Only loads leave data behind; stores and faults clear it
            if (state != RESP && state_nxt == RESP)
                resp_rdata <= (state == RD_CAPT && !store_q) ? load_data : 32'd0;
        end
    end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic fault_q;
    always_ff @(posedge clk) begin
        if (reset)                                      fault_q <= 1'b0;
        else if (state != RESP && state_nxt == RESP)    fault_q <= misalign;
        else if (state == RESP)                         fault_q <= 1'b0;
    end
    assign resp_fault = fault_q;
`else
    assign resp_fault = 1'b0;
`endif

    // Outputs; reset gates every bus strobe combinationally so a reset in WR writes nothing
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP) & ~reset;
        mem_en     = ((state == RD_ISSUE) | (state == WR)) & ~reset;
        mem_rnw    = ~((state == WR) & ~reset);
        mem_wdata  = ((state == WR) & ~reset) ? wdata_q : 32'd0;
        mem_addr   = {{(32 - ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a 256-word registered-read memory.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_store = 1'b0, req_byte = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_fault, mem_en, mem_rnw;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    int ncmp = 0, nerr = 0, cyc_cnt = 0, en_cnt = 0;
    logic [31:0] mem [0:255];
    logic        c1_en, c1_rnw, r_fault;
    logic [31:0] c1_addr, c1_wdata, r_data;
    int          acc_t [3];
    int          en0;

    mem_access_unit #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_en(mem_en), .mem_rnw(mem_rnw), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_en) en_cnt <= en_cnt + 1;
        if (mem_en && !mem_rnw) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && mem_rnw) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request, snapshots the bus one cycle after accept, checks latency
    // and leaves the response data/fault in r_data/r_fault.
    task automatic do_req(input logic st, input logic by, input logic [31:0] a, input logic [31:0] d,
                          input int lat, input string tag);
        int n;
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_store = st; req_byte = by; req_addr = a; req_wdata = d;
        tick;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'hCAFE_F00D;
        c1_en = mem_en; c1_rnw = mem_rnw; c1_addr = mem_addr; c1_wdata = mem_wdata;
        n = 1;
        while (!resp_valid && n < 8) begin
            tick;
            n++;
        end
        chk({tag, " latency"}, n, lat);
        r_data = resp_rdata;
        r_fault = resp_fault;
        tick;
        chk({tag, " ready_after"}, {31'd0, req_ready}, 32'd1);
        chk({tag, " valid_pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int n;
        tick;
        tick;
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst valid", {31'd0, resp_valid}, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst fault", {31'd0, resp_fault}, 32'd0);
        chk("rst en", {31'd0, mem_en}, 32'd0);
        chk("rst rnw", {31'd0, mem_rnw}, 32'd1);
        chk("rst wdata", mem_wdata, 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        reset = 1'b0;
        tick;

        do_req(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 2, "str");
        chk("str c1 en", {31'd0, c1_en}, 32'd1);
        chk("str c1 rnw", {31'd0, c1_rnw}, 32'd0);
        chk("str c1 addr", c1_addr, 32'd8);
        chk("str c1 wdata", c1_wdata, 32'hDEAD_BEEF);
        chk("str rdata", r_data, 32'd0);
        chk("str mem", mem[8], 32'hDEAD_BEEF);
        chk("idle wdata", mem_wdata, 32'd0);
        chk("idle addr hold", mem_addr, 32'd8);

        do_req(1'b0, 1'b0, 32'h20, 32'd0, 3, "ldr");
        chk("ldr c1 rnw", {31'd0, c1_rnw}, 32'd1);
        chk("ldr rdata", r_data, 32'hDEAD_BEEF);
        chk("ldr rdata hold", resp_rdata, 32'hDEAD_BEEF);

        do_req(1'b0, 1'b0, 32'h420, 32'd0, 3, "ldr wrap");
        chk("ldr wrap addr", c1_addr, 32'd8);
        chk("ldr wrap rdata", r_data, 32'hDEAD_BEEF);

        do_req(1'b1, 1'b0, 32'h08, 32'h1122_3344, 2, "str w2");
        chk("str w2 mem", mem[2], 32'h1122_3344);

        do_req(1'b0, 1'b1, 32'h08, 32'd0, 3, "ldrb0");
        chk("ldrb0 data", r_data, 32'h44);
        do_req(1'b0, 1'b1, 32'h09, 32'd0, 3, "ldrb1");
        chk("ldrb1 data", r_data, 32'h33);
        do_req(1'b0, 1'b1, 32'h0A, 32'd0, 3, "ldrb2");
        chk("ldrb2 data", r_data, 32'h22);
        do_req(1'b0, 1'b1, 32'h0B, 32'd0, 3, "ldrb3");
        chk("ldrb3 data", r_data, 32'h11);

        do_req(1'b1, 1'b1, 32'h0A, 32'hFFFF_FFAA, 4, "strb");
        chk("strb c1 rnw", {31'd0, c1_rnw}, 32'd1);
        chk("strb rdata", r_data, 32'd0);
        chk("strb mem", mem[2], 32'h11AA_3344);
        do_req(1'b0, 1'b0, 32'h08, 32'd0, 3, "ldr merged");
        chk("ldr merged data", r_data, 32'h11AA_3344);

        // Back-to-back word stores with req_valid held high
        req_valid = 1'b1; req_store = 1'b1; req_byte = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'h40 + 32'(4 * i);
            req_wdata = 32'(i + 1);
            n = 0;
            while (!req_ready && n < 8) begin
                tick;
                n++;
            end
            acc_t[i] = cyc_cnt;
            tick;
            chk("b2b busy", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        tick;
        tick;
        tick;
        chk("b2b gap1", acc_t[1] - acc_t[0], 32'd3);
        chk("b2b gap2", acc_t[2] - acc_t[1], 32'd3);
        chk("b2b mem0", mem[16], 32'd1);
        chk("b2b mem1", mem[17], 32'd2);
        chk("b2b mem2", mem[18], 32'd3);

        // Reset during the WR cycle of a byte store
        req_valid = 1'b1; req_store = 1'b1; req_byte = 1'b1; req_addr = 32'h41; req_wdata = 32'h55;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        chk("rstwr pre en", {31'd0, mem_en}, 32'd1);
        chk("rstwr pre rnw", {31'd0, mem_rnw}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rstwr en", {31'd0, mem_en}, 32'd0);
        chk("rstwr rnw", {31'd0, mem_rnw}, 32'd1);
        chk("rstwr wdata", mem_wdata, 32'd0);
        tick;
        reset = 1'b0;
        #1;
        chk("rstwr ready", {31'd0, req_ready}, 32'd1);
        chk("rstwr valid", {31'd0, resp_valid}, 32'd0);
        tick;
        chk("rstwr valid2", {31'd0, resp_valid}, 32'd0);
        chk("rstwr mem", mem[16], 32'd1);

        // Misaligned word load
        en0 = en_cnt;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        do_req(1'b0, 1'b0, 32'h22, 32'd0, 1, "mis");
        chk("mis fault", {31'd0, r_fault}, 32'd1);
        chk("mis rdata", r_data, 32'd0);
        chk("mis no mem", en_cnt - en0, 32'd0);
        chk("mis fault clr", {31'd0, resp_fault}, 32'd0);
`else
        do_req(1'b0, 1'b0, 32'h22, 32'd0, 3, "mis");
        chk("mis fault", {31'd0, r_fault}, 32'd0);
        chk("mis rdata", r_data, 32'hDEAD_BEEF);
        chk("mis mem cycles", en_cnt - en0, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
